// File: rtl/ker_wr_pkg.sv
// Shared types and constants for the kernel-RAM write controller.
package ker_wr_pkg;

  // Controller states
  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StStall,
    StDone
  } ker_wr_state_e;

  // Default widths
  localparam int unsigned DefInW       = 64;
  localparam int unsigned DefRamDw     = 32;
  localparam int unsigned DefAddrW     = 12;
  localparam int unsigned DefLayerW    = 7;
  localparam int unsigned DefRingLayers = 4;

  // RAM words per stream word; in_w must be a multiple of ram_dw
  function automatic int unsigned calc_ratio(input int unsigned in_w, input int unsigned ram_dw);
    return in_w / ram_dw;
  endfunction

endpackage

// File: rtl/ker_wr_slicer.sv
// Holds one stream word and hands it out one RAM-width slice per cycle, LSB slice first.
// The word stays put while hold_i is high; clr_i drops it and wins over load_i.
module ker_wr_slicer
  import ker_wr_pkg::*;
#(
  parameter int unsigned IN_W   = DefInW,
  parameter int unsigned RAM_DW = DefRamDw
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic              load_i,
  input  logic [IN_W-1:0]   data_i,
  input  logic              hold_i,
  output logic [RAM_DW-1:0] slice_o,
  output logic              empty_o,
  output logic              last_o
);

  localparam int unsigned RATIO = calc_ratio(IN_W, RAM_DW);
  localparam int unsigned IdxW  = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(RATIO - 1);

  logic [RATIO-1:0][RAM_DW-1:0] word_q, word_d;
  logic [IdxW-1:0]              idx_q, idx_d;
  logic                         full_q, full_d;

  assign slice_o = word_q[idx_q];
  assign empty_o = !full_q;
  assign last_o  = (idx_q == LastIdx);

  // Next buffer state: consume a slice, then load, then clear (highest priority)
  always_comb begin
    word_d = word_q;
    idx_d  = idx_q;
    full_d = full_q;
    if (full_q && !hold_i) begin
      if (last_o) begin
        full_d = 1'b0;
        idx_d  = '0;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
    if (load_i) begin
      word_d = data_i;
      idx_d  = '0;
      full_d = 1'b1;
    end
    if (clr_i) begin
      idx_d  = '0;
      full_d = 1'b0;
    end
  end

  // Buffer registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      word_q <= '0;
      idx_q  <= '0;
      full_q <= 1'b0;
    end else begin
      word_q <= word_d;
      idx_q  <= idx_d;
      full_q <= full_d;
    end
  end

endmodule

// File: rtl/ker_ram_write_ctrl.sv
// Kernel-RAM write controller: splits stream words into RAM words, writes them to sequential
// addresses, counts finished layers and, in ring mode, stalls until the reader frees a slot.
// Optional macro KER_WR_PARITY_EN adds ram_wr_par_o (even parity of ram_wr_data_o).
module ker_ram_write_ctrl
  import ker_wr_pkg::*;
#(
  parameter int unsigned IN_W        = DefInW,
  parameter int unsigned RAM_DW      = DefRamDw,
  parameter int unsigned ADDR_W      = DefAddrW,
  parameter int unsigned LAYER_W     = DefLayerW,
  parameter int unsigned RING_LAYERS = DefRingLayers
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               en_i,
  input  logic [ADDR_W-1:0]  tot_addr_limit_i,
  input  logic [LAYER_W-1:0] layer_addr_limit_i,
  input  logic               ring_en_i,
  input  logic [ADDR_W-1:0]  ring_addr_limit_i,
  input  logic               layer_release_i,
  input  logic [IN_W-1:0]    s_data_i,
  input  logic               s_valid_i,
  output logic               s_ready_o,
  output logic [RAM_DW-1:0]  ram_wr_data_o,
  output logic [ADDR_W-1:0]  ram_wr_addr_o,
  output logic               ram_wr_en_o,
  output logic [LAYER_W-1:0] layer_ready_no_o,
  output logic               busy_o,
  output logic               done_o
`ifdef KER_WR_PARITY_EN
  ,
  output logic               ram_wr_par_o
`endif
);

  localparam logic [LAYER_W-1:0] RingMax = LAYER_W'(RING_LAYERS);

  ker_wr_state_e state_q, state_d;

  logic [ADDR_W-1:0]  tot_lim_q, ring_lim_q;
  logic [LAYER_W-1:0] layer_lim_q;
  logic               ring_q;

  logic [ADDR_W-1:0]  addr_q, addr_d, tot_cnt_q, tot_cnt_d;
  logic [LAYER_W-1:0] layer_cnt_q, layer_cnt_d, layer_rdy_q, layer_rdy_d, outst_q, outst_d;

  logic               wr_en_q;
  logic [RAM_DW-1:0]  wr_data_q;
  logic [ADDR_W-1:0]  wr_addr_q;
  logic               wr_par_q;

  logic [RAM_DW-1:0]  slice;
  logic               buf_empty, buf_last;
  logic               stall_cond, hold, emit, last_wr, layer_end, rel_ok, hs;

  // No free ring slot and the next word would open a new layer
  assign stall_cond = ring_q && (layer_cnt_q == '0) && (outst_q >= RingMax);
  assign hold       = (state_q != StRun) || stall_cond;
  assign emit       = !buf_empty && !hold;
  assign last_wr    = emit && (tot_cnt_q == tot_lim_q);
  assign layer_end  = emit && (layer_cnt_q == layer_lim_q);
  assign rel_ok     = ring_q && layer_release_i && (outst_q != '0);
  // The final write must not pull in a word that would only be thrown away
  assign s_ready_o  = (state_q == StRun) && (buf_empty || (emit && buf_last && !last_wr));
  assign hs         = s_valid_i && s_ready_o;

  ker_wr_slicer #(
    .IN_W   (IN_W),
    .RAM_DW (RAM_DW)
  ) u_slicer (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (start_i || last_wr),
    .load_i  (hs),
    .data_i  (s_data_i),
    .hold_i  (hold),
    .slice_o (slice),
    .empty_o (buf_empty),
    .last_o  (buf_last)
  );

  // Next-state logic; start_i overrides everything
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  state_d = StIdle;
      StRun: begin
        if (last_wr) begin
          state_d = StDone;
        end else if (stall_cond) begin
          state_d = StStall;
        end
      end
      StStall: if (outst_q < RingMax) state_d = StRun;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (start_i) begin
      state_d = en_i ? StRun : StDone;
    end
  end

  // Address, word, layer and ring-credit counters
  always_comb begin
    addr_d      = addr_q;
    tot_cnt_d   = tot_cnt_q;
    layer_cnt_d = layer_cnt_q;
    layer_rdy_d = layer_rdy_q;
    outst_d     = outst_q;
    if (emit) begin
      addr_d    = (ring_q && (addr_q == ring_lim_q)) ? '0 : addr_q + 1'b1;
      tot_cnt_d = tot_cnt_q + 1'b1;
      if (layer_end) begin
        layer_cnt_d = '0;
        layer_rdy_d = layer_rdy_q + 1'b1;
      end else begin
        layer_cnt_d = layer_cnt_q + 1'b1;
      end
    end
    // Completion and release in the same cycle cancel out
    if (ring_q && layer_end && !rel_ok) begin
      outst_d = outst_q + 1'b1;
    end else if (!layer_end && rel_ok) begin
      outst_d = outst_q - 1'b1;
    end
    if (start_i) begin
      addr_d      = '0;
      tot_cnt_d   = '0;
      layer_cnt_d = '0;
      layer_rdy_d = '0;
      outst_d     = '0;
    end
  end

  // State and counter registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      tot_cnt_q   <= '0;
      layer_cnt_q <= '0;
      layer_rdy_q <= '0;
      outst_q     <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      tot_cnt_q   <= tot_cnt_d;
      layer_cnt_q <= layer_cnt_d;
      layer_rdy_q <= layer_rdy_d;
      outst_q     <= outst_d;
    end
  end

  // Configuration captured at start
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tot_lim_q   <= '0;
      layer_lim_q <= '0;
      ring_q      <= 1'b0;
      ring_lim_q  <= '0;
    end else if (start_i) begin
      tot_lim_q   <= tot_addr_limit_i;
      layer_lim_q <= layer_addr_limit_i;
      ring_q      <= ring_en_i;
      ring_lim_q  <= ring_addr_limit_i;
    end
  end

  // Registered RAM write port
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
      wr_addr_q <= '0;
      wr_par_q  <= 1'b0;
    end else begin
      wr_en_q <= emit && !start_i;
      if (emit) begin
        wr_data_q <= slice;
        wr_addr_q <= addr_q;
        wr_par_q  <= ^slice;
      end
    end
  end

  assign ram_wr_en_o      = wr_en_q;
  assign ram_wr_data_o    = wr_data_q;
  assign ram_wr_addr_o    = wr_addr_q;
  assign layer_ready_no_o = layer_rdy_q;
  assign busy_o           = (state_q == StRun) || (state_q == StStall);
  assign done_o           = (state_q == StDone);

`ifdef KER_WR_PARITY_EN
  assign ram_wr_par_o = wr_par_q;
`else
  logic unused_par;
  assign unused_par = wr_par_q;
`endif

endmodule

// File: tb/tb_ker_ram_write_ctrl.sv
// Directed bench for ker_ram_write_ctrl with a write scoreboard.
// Build with KER_WR_PARITY_EN defined to also check ram_wr_par_o.
module tb_ker_ram_write_ctrl;

  localparam int unsigned IN_W        = 64;
  localparam int unsigned RAM_DW      = 32;
  localparam int unsigned ADDR_W      = 12;
  localparam int unsigned LAYER_W     = 7;
  localparam int unsigned RING_LAYERS = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_i, start_i, en_i, ring_en_i, layer_release_i, s_valid_i;
  logic [ADDR_W-1:0]  tot_addr_limit_i, ring_addr_limit_i;
  logic [LAYER_W-1:0] layer_addr_limit_i;
  logic [IN_W-1:0]    s_data_i;
  logic               s_ready_o, ram_wr_en_o, busy_o, done_o;
  logic [RAM_DW-1:0]  ram_wr_data_o;
  logic [ADDR_W-1:0]  ram_wr_addr_o;
  logic [LAYER_W-1:0] layer_ready_no_o;
`ifdef KER_WR_PARITY_EN
  logic               ram_wr_par_o;
`endif

  ker_ram_write_ctrl #(
    .IN_W        (IN_W),
    .RAM_DW      (RAM_DW),
    .ADDR_W      (ADDR_W),
    .LAYER_W     (LAYER_W),
    .RING_LAYERS (RING_LAYERS)
  ) dut (
    .clk_i              (clk),
    .rst_i              (rst_i),
    .start_i            (start_i),
    .en_i               (en_i),
    .tot_addr_limit_i   (tot_addr_limit_i),
    .layer_addr_limit_i (layer_addr_limit_i),
    .ring_en_i          (ring_en_i),
    .ring_addr_limit_i  (ring_addr_limit_i),
    .layer_release_i    (layer_release_i),
    .s_data_i           (s_data_i),
    .s_valid_i          (s_valid_i),
    .s_ready_o          (s_ready_o),
    .ram_wr_data_o      (ram_wr_data_o),
    .ram_wr_addr_o      (ram_wr_addr_o),
    .ram_wr_en_o        (ram_wr_en_o),
    .layer_ready_no_o   (layer_ready_no_o),
    .busy_o             (busy_o),
    .done_o             (done_o)
`ifdef KER_WR_PARITY_EN
    ,
    .ram_wr_par_o       (ram_wr_par_o)
`endif
  );

  typedef struct {
    logic [ADDR_W-1:0]  addr;
    logic [RAM_DW-1:0]  data;
    logic [LAYER_W-1:0] layer;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   exp_k;
  int   ring_mod;
  int   layer_words;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Model: RAM word k of the fire lands at k mod ring size, and (k+1)/words_per_layer layers
  // are complete once it is written.
  function automatic void push_word(input logic [IN_W-1:0] d);
    exp_t e;
    for (int s = 0; s < 2; s++) begin
      e.addr  = ADDR_W'(exp_k % ring_mod);
      e.data  = d[s*RAM_DW +: RAM_DW];
      e.layer = LAYER_W'((exp_k + 1) / layer_words);
      exp_k++;
      sb.push_back(e);
    end
  endfunction

  // Write monitor: every RAM write must match the oldest expected entry
  always @(negedge clk) begin
    exp_t e;
    if (!rst_i && ram_wr_en_o) begin
      if (sb.size() == 0) begin
        check("unexpected_write", 64'(ram_wr_en_o), 64'(1'b0));
      end else begin
        e = sb.pop_front();
        check("wr_addr", 64'(ram_wr_addr_o), 64'(e.addr));
        check("wr_data", 64'(ram_wr_data_o), 64'(e.data));
        check("wr_layer_ready", 64'(layer_ready_no_o), 64'(e.layer));
`ifdef KER_WR_PARITY_EN
        check("wr_parity", 64'(ram_wr_par_o), 64'(^e.data));
`endif
      end
    end
  end

  task automatic do_start(input int tot, input int layer, input bit ring, input int rlim,
                          input bit en);
    tot_addr_limit_i   = ADDR_W'(tot);
    layer_addr_limit_i = LAYER_W'(layer);
    ring_en_i          = ring;
    ring_addr_limit_i  = ADDR_W'(rlim);
    en_i               = en;
    start_i            = 1'b1;
    exp_k              = 0;
    layer_words        = layer + 1;
    ring_mod           = ring ? rlim + 1 : (1 << ADDR_W);
    @(negedge clk);
    start_i            = 1'b0;
    // Config is latched; scramble it to prove that
    tot_addr_limit_i   = '0;
    layer_addr_limit_i = '0;
    ring_en_i          = !ring;
    ring_addr_limit_i  = '0;
    en_i               = 1'b0;
  endtask

  task automatic send(input logic [IN_W-1:0] d);
    bit ok = 1'b0;
    s_data_i  = d;
    s_valid_i = 1'b1;
    for (int n = 0; n < 60; n++) begin
      #1;
      if (s_ready_o) begin
        ok = 1'b1;
        push_word(d);
        break;
      end
      @(negedge clk);
    end
    if (!ok) check("send_accept_timeout", 64'(ok), 64'(1'b1));
    @(negedge clk);
    s_valid_i = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic release_pulse();
    layer_release_i = 1'b1;
    @(negedge clk);
    layer_release_i = 1'b0;
  endtask

  task automatic wait_done(input int last_addr, input int layers);
    bit seen = 1'b0;
    for (int n = 0; n < 60; n++) begin
      if (done_o) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("done_seen", 64'(seen), 64'(1'b1));
    check("done_final_wr_en", 64'(ram_wr_en_o), 64'(1'b1));
    check("done_final_addr", 64'(ram_wr_addr_o), 64'(last_addr));
    check("done_layers", 64'(layer_ready_no_o), 64'(layers));
    @(negedge clk);
    check("done_one_cycle", 64'(done_o), 64'(1'b0));
    check("ready_after_done", 64'(s_ready_o), 64'(1'b0));
    check("busy_after_done", 64'(busy_o), 64'(1'b0));
    check("sb_drained", 64'(sb.size()), 64'(0));
  endtask

  initial begin
    #500000;
    $fatal(1, "FAIL global_timeout: simulation did not finish");
  end

  initial begin
    bit found;
    rst_i = 1'b1; start_i = 1'b0; en_i = 1'b0; ring_en_i = 1'b0; layer_release_i = 1'b0;
    s_valid_i = 1'b0; s_data_i = '0; tot_addr_limit_i = '0; ring_addr_limit_i = '0;
    layer_addr_limit_i = '0;
    exp_k = 0; ring_mod = 1 << ADDR_W; layer_words = 1;
    idle(3);
    check("rst_wr_en", 64'(ram_wr_en_o), 64'(0));
    check("rst_wr_addr", 64'(ram_wr_addr_o), 64'(0));
    check("rst_wr_data", 64'(ram_wr_data_o), 64'(0));
    check("rst_layer_ready", 64'(layer_ready_no_o), 64'(0));
    check("rst_busy", 64'(busy_o), 64'(0));
    check("rst_done", 64'(done_o), 64'(0));
    check("rst_ready", 64'(s_ready_o), 64'(0));
`ifdef KER_WR_PARITY_EN
    check("rst_parity", 64'(ram_wr_par_o), 64'(0));
`endif
    rst_i = 1'b0;
    idle(1);

    // Full-rate stream, ring off
    do_start(7, 3, 1'b0, 0, 1'b1);
    check("t1_busy", 64'(busy_o), 64'(1));
    send(64'h0123_4567_0000_0007);
    send(64'h89AB_CDEF_1111_2222);
    send(64'h3333_4444_5555_6666);
    send(64'hFEDC_BA98_7654_3210);
    wait_done(7, 2);

    // Gapped stream
    do_start(7, 3, 1'b0, 0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      send({32'(32'hA000_0000 + i), 32'(32'h0000_0B00 + i)});
      idle(1);
    end
    wait_done(7, 2);

    // Disabled layer goes straight to DONE
    do_start(7, 3, 1'b0, 0, 1'b0);
    check("en0_done", 64'(done_o), 64'(1));
    check("en0_busy", 64'(busy_o), 64'(0));
    idle(1);
    check("en0_done_gone", 64'(done_o), 64'(0));

    // Restart mid-fire after addr 5; the word offered with start is dropped
    do_start(7, 3, 1'b0, 0, 1'b1);
    send(64'h1000_0001_1000_0000);
    send(64'h1000_0003_1000_0002);
    send(64'h1000_0005_1000_0004);
    for (int n = 0; n < 20 && sb.size() != 0; n++) @(negedge clk);
    idle(2);
    check("t5_pre_addr", 64'(ram_wr_addr_o), 64'(5));
    check("t5_pre_layers", 64'(layer_ready_no_o), 64'(1));
    s_data_i  = 64'hBAD0_BAD0_BAD0_BAD0;
    s_valid_i = 1'b1;
    do_start(7, 3, 1'b0, 0, 1'b1);
    s_valid_i = 1'b0;
    check("t5_layers_cleared", 64'(layer_ready_no_o), 64'(0));
    check("t5_buffer_empty", 64'(s_ready_o), 64'(1));
    send(64'h2000_0001_2000_0000);
    send(64'h2000_0003_2000_0002);
    send(64'h2000_0005_2000_0004);
    send(64'h2000_0007_2000_0006);
    wait_done(7, 2);

    // Ring mode: 2 slots, 2 RAM words per layer, 4-word ring
    do_start(11, 1, 1'b1, 3, 1'b1);
    release_pulse();  // nothing outstanding: must be ignored
    send(64'h3000_0001_3000_0000);
    send(64'h3000_0003_3000_0002);
    send(64'h3000_0005_3000_0004);
    idle(8);
    check("ring_stall1_busy", 64'(busy_o), 64'(1));
    check("ring_stall1_ready", 64'(s_ready_o), 64'(0));
    check("ring_stall1_layers", 64'(layer_ready_no_o), 64'(2));
    check("ring_stall1_pending", 64'(sb.size()), 64'(2));
    release_pulse();
    // Release again exactly as the resumed layer completes
    found = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (ram_wr_en_o && ram_wr_addr_o == '0) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("ring_resume_addr0", 64'(found), 64'(1'b1));
    release_pulse();
    send(64'h3000_0007_3000_0006);
    send(64'h3000_0009_3000_0008);
    idle(8);
    check("ring_stall2_ready", 64'(s_ready_o), 64'(0));
    check("ring_stall2_layers", 64'(layer_ready_no_o), 64'(4));
    check("ring_stall2_pending", 64'(sb.size()), 64'(2));
    release_pulse();
    send(64'h3000_000B_3000_000A);
    idle(8);
    check("ring_stall3_layers", 64'(layer_ready_no_o), 64'(5));
    check("ring_stall3_pending", 64'(sb.size()), 64'(2));
    release_pulse();
    wait_done(3, 6);

    // Reset while stalled
    do_start(11, 1, 1'b1, 3, 1'b1);
    send(64'h4000_0001_4000_0000);
    send(64'h4000_0003_4000_0002);
    send(64'h4000_0005_4000_0004);
    idle(6);
    check("rst_stall_busy", 64'(busy_o), 64'(1));
    rst_i = 1'b1;
    @(negedge clk);
    check("rst2_wr_en", 64'(ram_wr_en_o), 64'(0));
    check("rst2_wr_addr", 64'(ram_wr_addr_o), 64'(0));
    check("rst2_wr_data", 64'(ram_wr_data_o), 64'(0));
    check("rst2_layer_ready", 64'(layer_ready_no_o), 64'(0));
    check("rst2_busy", 64'(busy_o), 64'(0));
    check("rst2_ready", 64'(s_ready_o), 64'(0));
`ifdef KER_WR_PARITY_EN
    check("rst2_parity", 64'(ram_wr_par_o), 64'(0));
`endif
    rst_i = 1'b0;
    sb.delete();
    idle(2);
    check("rst2_idle_busy", 64'(busy_o), 64'(0));
    check("rst2_idle_wr_en", 64'(ram_wr_en_o), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
